// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> backing memory interface:
// default widths, responder FSM encoding and the request bundle.
package mem_if_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [MEM_ADDR_W-1:0] rd_addr;
        logic [MEM_ADDR_W-1:0] wr_addr;
        logic [MEM_DATA_W-1:0] wr_data;
    } mem_req_t;

endpackage

// File: rtl/backing_mem_responder_array.sv
// Storage array for the backing memory: 2**ADDR_W x DATA_W words.
// Ports: clk_i, rst_ni (async, resets mem[a]=a), one write port
// (we_i/waddr_i/wdata_i), one combinational read port (raddr_i/rdata_o).
module mem_storage_array
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset loads each word with its own address so contents are known.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= DATA_W'(a);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/backing_mem_responder.sv
// Fixed-latency main-memory responder serving cache fills and write-backs.
// Ports: Clk, Reset (async active-low), ReqValid/ReqReady handshake,
// ReqRd/ReqWr/RdAddress/WrAddress/WrData request, AckValid/RspData response.
module backing_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int LATENCY = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqRd,
    input  logic              ReqWr,
    input  logic [ADDR_W-1:0] RdAddress,
    input  logic [ADDR_W-1:0] WrAddress,
    input  logic [DATA_W-1:0] WrData,
    output logic              AckValid,
    output logic [DATA_W-1:0] RspData
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;

    logic              accept;
    logic              go_ack;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign accept = ReqValid && (state_q == ST_IDLE)
                 && (ReqRd || ReqWr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.rd      = ReqRd;
                    req_d.wr      = ReqWr;
                    req_d.rd_addr = RdAddress;
                    req_d.wr_addr = WrAddress;
                    req_d.wr_data = WrData;
                    cnt_d         = CNT_INIT;
                    state_d       = (LATENCY == 1) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Commit happens on the edge entering ACK. req_d is used so that a
    // LATENCY==1 build commits the request being captured on that edge.
    assign go_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
    assign mem_we = go_ack && req_d.wr;

    always_comb begin
        rsp_d = rsp_q;
        if (go_ack && req_d.rd) begin
            // The array read port sees pre-write contents: bypass.
            if (req_d.wr && (req_d.wr_addr == req_d.rd_addr)) begin
                rsp_d = req_d.wr_data;
            end else begin
                rsp_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
        end
    end

    mem_storage_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .we_i    (mem_we),
        .waddr_i (req_d.wr_addr),
        .wdata_i (req_d.wr_data),
        .raddr_i (req_d.rd_addr),
        .rdata_o (mem_rdata)
    );

    assign ReqReady = (state_q == ST_IDLE);
    assign AckValid = (state_q == ST_ACK);
    assign RspData  = rsp_q;

endmodule

// File: tb/tb_backing_mem_responder.sv
// Scoreboard bench for backing_mem_responder: a LATENCY=3 and a
// LATENCY=1 instance share request fields, each with its own valid.
module tb_backing_mem_responder;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic       Clk;
    logic       Reset;
    logic       rv0, rv1;
    logic       rdy0, rdy1;
    logic       rd, wr;
    logic [5:0] ra, wa;
    logic [7:0] wd;
    logic       ack0, ack1;
    logic [7:0] rsp0, rsp1;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t q0[$];
    exp_t q1[$];

    backing_mem_responder #(.ADDR_W(6), .DATA_W(8), .LATENCY(3)) dut0 (
        .Clk(Clk), .Reset(Reset), .ReqValid(rv0), .ReqReady(rdy0),
        .ReqRd(rd), .ReqWr(wr), .RdAddress(ra), .WrAddress(wa),
        .WrData(wd), .AckValid(ack0), .RspData(rsp0)
    );

    backing_mem_responder #(.ADDR_W(6), .DATA_W(8), .LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .ReqValid(rv1), .ReqReady(rdy1),
        .ReqRd(rd), .ReqWr(wr), .RdAddress(ra), .WrAddress(wa),
        .WrData(wd), .AckValid(ack1), .RspData(rsp1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation whenever an instance acks.
    always @(negedge Clk) begin
        if (Reset && ack0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack0_unexpected: got ack, want none (cyc %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("rsp0_data", int'(rsp0), e.data);
                chk("rsp0_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset && ack1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack1_unexpected: got ack, want none (cyc %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("rsp1_data", int'(rsp1), e.data);
                chk("rsp1_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request; returns the cycle index right after accept.
    task automatic issue(input int sel, input logic r, input logic w,
                         input logic [5:0] radr, input logic [5:0] wadr,
                         input logic [7:0] wdat, input bit push,
                         input int exp_data, output int acc);
        int n;
        exp_t e;
        n = 0;
        @(negedge Clk);
        while (!(sel == 1 ? rdy1 : rdy0) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 0, 1);
        rd = r;
        wr = w;
        ra = radr;
        wa = wadr;
        wd = wdat;
        if (sel == 1) rv1 = 1'b1;
        else          rv0 = 1'b1;
        @(posedge Clk);
        #1;
        acc = cyc;
        rv0 = 1'b0;
        rv1 = 1'b0;
        e.data = exp_data;
        if (push) begin
            if (sel == 1) begin
                e.cyc = acc;
                q1.push_back(e);
            end else begin
                e.cyc = acc + 2;
                q0.push_back(e);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !rdy0 || !rdy1)
               && n < 60) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 60) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int   acc;
        int   nacc;
        int   acc_c[$];
        exp_t e;

        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;
        rv0 = 0; rv1 = 0; rd = 0; wr = 0;
        ra = '0; wa = '0; wd = '0;
        repeat (2) @(negedge Clk);
        chk("rst_ready", int'(rdy0), 1);
        chk("rst_ack", int'(ack0), 0);
        chk("rst_rsp", int'(rsp0), 0);
        Reset = 1'b1;

        // 1: plain fill, ready low for three cycles
        issue(0, 1, 0, 6'h2A, 6'h00, 8'h00, 1, 8'h2A, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("t1_ready_low", int'(rdy0), 0);
        end
        @(negedge Clk);
        chk("t1_ready_back", int'(rdy0), 1);
        wait_done();

        // 2: write-only keeps RspData, then read back
        issue(0, 0, 1, 6'h00, 6'h05, 8'hC3, 1, 8'h2A, acc);
        wait_done();
        issue(0, 1, 0, 6'h05, 6'h00, 8'h00, 1, 8'hC3, acc);
        wait_done();

        // 3: combined requests, bypass and distinct addresses
        issue(0, 1, 1, 6'h11, 6'h11, 8'h7E, 1, 8'h7E, acc);
        wait_done();
        issue(0, 1, 1, 6'h12, 6'h11, 8'h55, 1, 8'h12, acc);
        wait_done();
        issue(0, 1, 0, 6'h11, 6'h00, 8'h00, 1, 8'h55, acc);
        wait_done();

        // 4a: valid held high, address changes every cycle
        @(negedge Clk);
        rv0 = 1'b1; rd = 1'b1; wr = 1'b0;
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            ra = 6'(i);
            if (rdy0) begin
                e.data = i;
                e.cyc  = cyc + 3;
                q0.push_back(e);
                acc_c.push_back(cyc + 1);
                nacc++;
            end
            @(negedge Clk);
        end
        rv0 = 1'b0;
        chk("t4_accepts", nacc, 3);
        if (acc_c.size() == 3) begin
            chk("t4_gap1", acc_c[1] - acc_c[0], 4);
            chk("t4_gap2", acc_c[2] - acc_c[1], 4);
        end
        wait_done();

        // 4b: valid with neither rd nor wr is not accepted
        @(negedge Clk);
        rv0 = 1'b1; rd = 1'b0; wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("t4_noop_ready", int'(rdy0), 1);
        end
        rv0 = 1'b0;

        // 4c: inputs wiggled during WAIT are ignored
        issue(0, 1, 0, 6'h30, 6'h00, 8'h00, 1, 8'h30, acc);
        @(negedge Clk);
        ra = 6'h3F; wr = 1'b1; wa = 6'h30; wd = 8'hAA;
        wait_done();
        issue(0, 1, 0, 6'h30, 6'h00, 8'h00, 1, 8'h30, acc);
        wait_done();

        // 5: reset one cycle after accepting a write
        issue(0, 0, 1, 6'h00, 6'h20, 8'hFF, 0, 0, acc);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("t5_ready", int'(rdy0), 1);
        chk("t5_ack", int'(ack0), 0);
        chk("t5_rsp", int'(rsp0), 0);
        @(negedge Clk);
        chk("t5_ack_held", int'(ack0), 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("t5_ready_rel", int'(rdy0), 1);
        issue(0, 1, 0, 6'h20, 6'h00, 8'h00, 1, 8'h20, acc);
        wait_done();
        issue(0, 1, 0, 6'h05, 6'h00, 8'h00, 1, 8'h05, acc);
        wait_done();

        // 6: LATENCY=1 instance
        issue(1, 1, 0, 6'h3F, 6'h00, 8'h00, 1, 8'h3F, acc);
        @(negedge Clk);
        chk("t6_ready_ack", int'(rdy1), 0);
        @(negedge Clk);
        chk("t6_ready_back", int'(rdy1), 1);
        issue(1, 1, 1, 6'h3F, 6'h3F, 8'h99, 1, 8'h99, acc);
        wait_done();
        issue(1, 1, 0, 6'h3F, 6'h00, 8'h00, 1, 8'h99, acc);
        wait_done();

        repeat (3) @(negedge Clk);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
